// File: rtl/lenet_pkg.sv
// Shared types and defaults for the LeNet run controller.
// The state encoding is exported so that observers can decode it.
package lenet_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        BUSY = 2'd2,
        HOLD = 2'd3
    } run_state_t;

    localparam int DIGIT_W      = 4;
    localparam int DEF_INTERVAL = 5_000_000;
    localparam int DEF_TIMEOUT  = 1_000_000;
    localparam int DEF_CNT_W    = 32;
    localparam int DEF_RUN_W    = 16;

endpackage

// File: rtl/ctrl_timer.sv
// Clearable up-counter that flags the cycle its count equals LIMIT-1.
// Clear has priority over increment so a hit can restart the count in the same cycle.
module ctrl_timer #(
    parameter int CNT_W = 32,
    parameter int LIMIT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic hit_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = (cnt_q == LAST);

endmodule

// File: rtl/lenet_run_ctrl.sv
// Run sequencer for the LeNet core: fires go on an interval or trigger, waits for
// ready with a timeout, and holds the classified digit until the consumer acks it.
module lenet_run_ctrl
    import lenet_pkg::*;
#(
    parameter int INTERVAL = DEF_INTERVAL,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int RUN_W    = DEF_RUN_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               trig,
    output logic               go,
    input  logic               ready,
    input  logic [DIGIT_W-1:0] digit_in,
    output logic [DIGIT_W-1:0] res_digit,
    output logic               res_valid,
    input  logic               res_ack,
    output logic               busy,
    output logic               timeout_err,
    input  logic               err_clr,
    output logic [RUN_W-1:0]   run_cnt
);

    run_state_t         state_q, state_d;
    logic               go_q, go_d;
    logic               res_valid_q, res_valid_d;
    logic [DIGIT_W-1:0] res_digit_q, res_digit_d;
    logic               err_q, err_d;
    logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;

    logic ivl_hit, ivl_clr, ivl_inc;
    logic to_hit, to_clr, to_inc;
    logic fire_req;

    // The interval only advances while idle and enabled; any exit from IDLE restarts it.
    assign fire_req = (state_q == IDLE) && (trig || (en && ivl_hit));
    assign ivl_inc  = (state_q == IDLE) && en;
    assign ivl_clr  = (state_q != IDLE) || !en || fire_req;
    assign to_inc   = (state_q == BUSY);
    assign to_clr   = (state_q != BUSY);

    ctrl_timer #(
        .CNT_W (CNT_W),
        .LIMIT (INTERVAL)
    ) u_interval (
        .clk   (clk),
        .rst   (rst),
        .clr_i (ivl_clr),
        .inc_i (ivl_inc),
        .hit_o (ivl_hit)
    );

    ctrl_timer #(
        .CNT_W (CNT_W),
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .rst   (rst),
        .clr_i (to_clr),
        .inc_i (to_inc),
        .hit_o (to_hit)
    );

    always_comb begin
        state_d     = state_q;
        res_valid_d = res_valid_q;
        res_digit_d = res_digit_q;
        run_cnt_d   = run_cnt_q;
        err_d       = err_q;

        if (err_clr) begin
            err_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (fire_req) begin
                    state_d = FIRE;
                end
            end
            FIRE: begin
                state_d = BUSY;
            end
            BUSY: begin
                // ready outranks a coincident timeout; a timeout outranks err_clr.
                if (ready) begin
                    res_digit_d = digit_in;
                    res_valid_d = 1'b1;
                    run_cnt_d   = run_cnt_q + RUN_W'(1);
                    state_d     = HOLD;
                end else if (to_hit) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (res_ack && res_valid_q) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        go_d = (state_d == FIRE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            go_q        <= 1'b0;
            res_valid_q <= 1'b0;
            res_digit_q <= '0;
            err_q       <= 1'b0;
            run_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            go_q        <= go_d;
            res_valid_q <= res_valid_d;
            res_digit_q <= res_digit_d;
            err_q       <= err_d;
            run_cnt_q   <= run_cnt_d;
        end
    end

    assign go          = go_q;
    assign res_valid   = res_valid_q;
    assign res_digit   = res_digit_q;
    assign timeout_err = err_q;
    assign run_cnt     = run_cnt_q;
    assign busy        = (state_q != IDLE);

    a_go_single : assert property (@(posedge clk) disable iff (rst) go_q |=> !go_q);
    a_hold_valid : assert property (@(posedge clk) disable iff (rst)
        (state_q == HOLD) |-> res_valid_q);

endmodule
